axi_slave_interface_mt: RTL

// - Multi-outstanding AXI4 slave front-end between an AXI interconnect and the PyCoRAM user bus.
// - Tracks up to C_OUTSTANDING write and read transactions in per-channel ID FIFOs.
// - BID/RID follow the issuing AWID/ARID in order. RLAST is generated from the stored ARLEN.
// - User-side error inputs map to SLVERR responses.

---
 rtl/axi_pkg.sv | 21 ++
 rtl/axi_id_fifo.sv | 62 ++++++
 rtl/axi_slave_interface_mt.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI definitions: burst and response encodings
// plus a constant clog2 helper used for counter widths.
package axi_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/axi_id_fifo.sv
// Synchronous FWFT FIFO with a registered head word.
// Ports: clk, rst (sync, high), push/din, pop, head, full, empty, count.
module axi_id_fifo
   import axi_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       din,
   input  logic                   pop,
   output logic [WIDTH-1:0]       head,
   output logic                   full,
   output logic                   empty,
   output logic [clog2(DEPTH):0]  count
);

   localparam int AW = clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [AW-1:0]    rnext;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign rnext   = rptr + 1'b1;

   always_ff @(posedge clk) begin
      if (push_ok) mem[wptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         head  <= '0;
      end else begin
         if (push_ok) wptr <= wptr + 1'b1;
         if (pop_ok)  rptr <= rnext;
         if (push_ok && !pop_ok)
            count <= count + 1'b1;
         else if (pop_ok && !push_ok)
            count <= count - 1'b1;
         // Head tracks the oldest entry; a push into a
         // FIFO that is (or becomes) empty bypasses mem.
         if (pop_ok)
            head <= (push_ok && count == (AW+1)'(1))
                    ? din : mem[rnext];
         else if (push_ok && empty)
            head <= din;
      end
   end

endmodule

// File: rtl/axi_slave_interface_mt.sv
// AXI4 slave front-end to the PyCoRAM user bus with in-order
// ID tracking, RLAST generation and SLVERR mapping.
// Ports: ACLK/ARESET, S_AXI_* slave channels, user aw/w/b/ar/r
// channels, wr/rd_outstanding occupancy and sticky rlast_mismatch.
module axi_slave_interface_mt
   import axi_pkg::*;
#(
   parameter int C_S_AXI_ID_WIDTH   = 1,
   parameter int C_S_AXI_ADDR_WIDTH = 32,
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_USER_WIDTH = 1,
   parameter int C_OUTSTANDING      = 4
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   // AXI write address
   input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [7:0]                      S_AXI_AWLEN,
   input  logic [2:0]                      S_AXI_AWSIZE,
   input  logic [1:0]                      S_AXI_AWBURST,
   input  logic                            S_AXI_AWLOCK,
   input  logic [3:0]                      S_AXI_AWCACHE,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic [3:0]                      S_AXI_AWQOS,
   input  logic [C_S_AXI_USER_WIDTH-1:0]   S_AXI_AWUSER,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   // AXI write data
   input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_WID,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WLAST,
   input  logic [C_S_AXI_USER_WIDTH-1:0]   S_AXI_WUSER,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   // AXI write response
   output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
   output logic [1:0]                      S_AXI_BRESP,
   output logic [C_S_AXI_USER_WIDTH-1:0]   S_AXI_BUSER,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   // AXI read address
   input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [7:0]                      S_AXI_ARLEN,
   input  logic [2:0]                      S_AXI_ARSIZE,
   input  logic [1:0]                      S_AXI_ARBURST,
   input  logic                            S_AXI_ARLOCK,
   input  logic [3:0]                      S_AXI_ARCACHE,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic [3:0]                      S_AXI_ARQOS,
   input  logic [C_S_AXI_USER_WIDTH-1:0]   S_AXI_ARUSER,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   // AXI read data
   output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RLAST,
   output logic [C_S_AXI_USER_WIDTH-1:0]   S_AXI_RUSER,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   // User bus
   output logic                            awvalid,
   output logic [C_S_AXI_ADDR_WIDTH-1:0]   awaddr,
   output logic [7:0]                      awlen,
   input  logic                            awready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   wdata,
   output logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb,
   output logic                            wlast,
   output logic                            wvalid,
   input  logic                            wready,
   input  logic                            bvalid,
   output logic                            bready,
   input  logic                            berr,
   output logic                            arvalid,
   output logic [C_S_AXI_ADDR_WIDTH-1:0]   araddr,
   output logic [7:0]                      arlen,
   input  logic                            arready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   rdata,
   input  logic                            rlast,
   input  logic                            rvalid,
   output logic                            rready,
   input  logic                            rerr,
   output logic [clog2(C_OUTSTANDING):0]   wr_outstanding,
   output logic [clog2(C_OUTSTANDING):0]   rd_outstanding,
   output logic                            rlast_mismatch
);

   localparam int IW = C_S_AXI_ID_WIDTH;

   logic          wfull, wempty, rfull, rempty;
   logic          aw_hs, b_hs, ar_hs, r_hs;
   logic [IW-1:0] whead_id;
   logic [IW+7:0] rhead;
   logic [IW-1:0] rhead_id;
   logic [7:0]    rhead_len;
   logic [7:0]    rbeat;

   // Sideband fields the user bus has no place for.
   logic unused_sideband;
   assign unused_sideband = ^{S_AXI_AWSIZE, S_AXI_AWBURST,
      S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS,
      S_AXI_AWUSER, S_AXI_WID, S_AXI_WUSER, S_AXI_ARSIZE,
      S_AXI_ARBURST, S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT,
      S_AXI_ARQOS, S_AXI_ARUSER};

   // Write address
   assign awvalid       = S_AXI_AWVALID & ~wfull;
   assign awaddr        = S_AXI_AWADDR;
   assign awlen         = S_AXI_AWLEN;
   assign S_AXI_AWREADY = awready & ~wfull & ~ARESET;
   assign aw_hs         = S_AXI_AWVALID & S_AXI_AWREADY;

   // Write data
   assign wdata         = S_AXI_WDATA;
   assign wstrb         = S_AXI_WSTRB;
   assign wlast         = S_AXI_WLAST;
   assign wvalid        = S_AXI_WVALID;
   assign S_AXI_WREADY  = wready;

   // Write response
   assign S_AXI_BVALID  = bvalid & ~wempty & ~ARESET;
   assign bready        = S_AXI_BREADY & ~wempty;
   assign S_AXI_BID     = whead_id;
   assign S_AXI_BRESP   = berr ? RESP_SLVERR : RESP_OKAY;
   assign S_AXI_BUSER   = '0;
   assign b_hs          = S_AXI_BVALID & S_AXI_BREADY;

   // Read address
   assign arvalid       = S_AXI_ARVALID & ~rfull;
   assign araddr        = S_AXI_ARADDR;
   assign arlen         = S_AXI_ARLEN;
   assign S_AXI_ARREADY = arready & ~rfull & ~ARESET;
   assign ar_hs         = S_AXI_ARVALID & S_AXI_ARREADY;

   // Read data
   assign rhead_id      = rhead[IW+7:8];
   assign rhead_len     = rhead[7:0];
   assign S_AXI_RVALID  = rvalid & ~rempty & ~ARESET;
   assign rready        = S_AXI_RREADY & ~rempty;
   assign S_AXI_RID     = rhead_id;
   assign S_AXI_RDATA   = rdata;
   assign S_AXI_RRESP   = rerr ? RESP_SLVERR : RESP_OKAY;
   assign S_AXI_RLAST   = (rbeat == rhead_len);
   assign S_AXI_RUSER   = '0;
   assign r_hs          = S_AXI_RVALID & S_AXI_RREADY;

   axi_id_fifo #(
      .WIDTH (IW),
      .DEPTH (C_OUTSTANDING)
   ) u_wfifo (
      .clk   (ACLK),
      .rst   (ARESET),
      .push  (aw_hs),
      .din   (S_AXI_AWID),
      .pop   (b_hs),
      .head  (whead_id),
      .full  (wfull),
      .empty (wempty),
      .count (wr_outstanding)
   );

   axi_id_fifo #(
      .WIDTH (IW + 8),
      .DEPTH (C_OUTSTANDING)
   ) u_rfifo (
      .clk   (ACLK),
      .rst   (ARESET),
      .push  (ar_hs),
      .din   ({S_AXI_ARID, S_AXI_ARLEN}),
      .pop   (r_hs & S_AXI_RLAST),
      .head  (rhead),
      .full  (rfull),
      .empty (rempty),
      .count (rd_outstanding)
   );

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         rbeat          <= '0;
         rlast_mismatch <= 1'b0;
      end else if (r_hs) begin
         rbeat <= S_AXI_RLAST ? 8'd0 : rbeat + 8'd1;
         if (rlast != S_AXI_RLAST) rlast_mismatch <= 1'b1;
      end
   end

endmodule
